// File: rtl/fb_pkg.sv
// Shared FSM encoding and default widths for the ping-pong frame buffer controller.
package fb_pkg;
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_SWAP = 2'd2
    } fb_state_e;

    localparam int FB_DATA_WIDTH = 16;
    localparam int FB_ADDR_WIDTH = 3;
endpackage

// File: rtl/fb_skid_buf.sv
// Two-entry output FIFO between the memory read port and the sink.
// count_o lets the controller budget read credits against what is already held.
module fb_skid_buf
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic [1:0]            count_o
);
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_idx_q;
    logic                  rd_idx_q;
    logic [1:0]            cnt_q;
    logic                  push;
    logic                  pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_idx_q];
    assign count_o     = cnt_q;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) wr_idx_q <= ~wr_idx_q;
            if (pop)  rd_idx_q <= ~rd_idx_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx_q] <= in_data_i;
    end
endmodule

// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame buffer controller: one bank is written while the other is read out.
// Build option FB_DROP_EN: keep in_ready high and count words that arrive with no room.
module fb_pingpong_ctrl
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_WIDTH,
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  bank_sel,
    output logic [7:0]            swap_cnt,
    output logic [15:0]           drop_cnt
);
    localparam int                    PW        = ADDR_WIDTH - 1;
    localparam logic [PW-1:0]         LAST_PTR  = '1;
    localparam logic [ADDR_WIDTH-1:0] FRAME_LEN = ADDR_WIDTH'(2 ** PW);

    fb_state_e             state_q, state_d;
    logic                  bank_sel_q, bank_sel_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic                  wr_full_q, wr_full_d;
    logic [ADDR_WIDTH-1:0] rd_issued_q, rd_issued_d;
    logic                  rd_inflight_q;
    logic [7:0]            swap_cnt_q, swap_cnt_d;

    logic       in_blocked;
    logic       wr_fire;
    logic       rd_fire;
    logic       pop;
    logic       buf_in_ready;
    logic [1:0] buf_cnt;
    logic [1:0] lvl;

    assign in_blocked = wr_full_q | (state_q == ST_SWAP);
`ifdef FB_DROP_EN
    assign in_ready = ~reset;
`else
    assign in_ready = ~reset & ~in_blocked;
`endif
    assign wr_fire     = in_valid & in_ready & ~in_blocked;
    assign mem_wr_en   = wr_fire;
    assign mem_wr_addr = {bank_sel_q, wr_ptr_q};
    assign mem_wr_data = in_data;

    // A pop this cycle frees a slot in time for a read issued now, giving 1 word/cycle.
    assign pop         = out_valid & out_ready;
    assign lvl         = buf_cnt + {1'b0, rd_inflight_q};
    assign rd_fire     = ~reset & (state_q == ST_RUN) & (rd_issued_q < FRAME_LEN)
                       & ((lvl < 2'd2) | pop);
    assign mem_rd_en   = rd_fire;
    assign mem_rd_addr = {~bank_sel_q, rd_issued_q[PW-1:0]};

    fb_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_obuf (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (rd_inflight_q & buf_in_ready),
        .in_data_i   (mem_rd_data),
        .in_ready_o  (buf_in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .count_o     (buf_cnt)
    );

    always_comb begin
        state_d     = state_q;
        bank_sel_d  = bank_sel_q;
        wr_ptr_d    = wr_ptr_q + PW'(wr_fire);
        wr_full_d   = wr_full_q | (wr_fire & (wr_ptr_q == LAST_PTR));
        rd_issued_d = rd_issued_q + ADDR_WIDTH'(rd_fire);
        swap_cnt_d  = swap_cnt_q;
        unique case (state_q)
            ST_FILL: if (wr_full_d) state_d = ST_SWAP;
            ST_RUN:  if (wr_full_d && (rd_issued_d == FRAME_LEN)) state_d = ST_SWAP;
            ST_SWAP: begin
                state_d     = ST_RUN;
                bank_sel_d  = ~bank_sel_q;
                wr_ptr_d    = '0;
                wr_full_d   = 1'b0;
                rd_issued_d = '0;
                swap_cnt_d  = swap_cnt_q + 8'd1;
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FILL;
            bank_sel_q    <= 1'b0;
            wr_ptr_q      <= '0;
            wr_full_q     <= 1'b0;
            rd_issued_q   <= '0;
            rd_inflight_q <= 1'b0;
            swap_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            bank_sel_q    <= bank_sel_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_full_q     <= wr_full_d;
            rd_issued_q   <= rd_issued_d;
            rd_inflight_q <= rd_fire;
            swap_cnt_q    <= swap_cnt_d;
        end
    end

    assign bank_sel = bank_sel_q;
    assign swap_cnt = swap_cnt_q;

`ifdef FB_DROP_EN
    logic [15:0] drop_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= 16'd0;
        end else if (in_valid && in_ready && in_blocked && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// Directed bench for fb_pingpong_ctrl (FRAME_LEN = 4) with a 1-cycle-latency memory model.
module tb_fb_pingpong_ctrl;
    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data, mem_wr_data, mem_rd_data;
    logic          mem_wr_en, mem_rd_en, bank_sel;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [7:0]    swap_cnt;
    logic [15:0]   drop_cnt;

    fb_pingpong_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .bank_sel(bank_sel), .swap_cnt(swap_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [8];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    logic [AW-1:0] rd_addr_q [$];
    logic [DW-1:0] out_q [$];
    int            out_cyc [$];
    int            cyc = 0, n_iss = 0, n_pop = 0, max_lvl = 0;

    // Words issued but not yet popped = buffered + in flight after this edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            n_iss = 0;
            n_pop = 0;
        end else begin
            if (mem_wr_en) begin
                wr_addr_q.push_back(mem_wr_addr);
                wr_data_q.push_back(mem_wr_data);
            end
            if (mem_rd_en) begin
                rd_addr_q.push_back(mem_rd_addr);
                n_iss = n_iss + 1;
            end
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                out_cyc.push_back(cyc);
                n_pop = n_pop + 1;
            end
            if (n_iss - n_pop > max_lvl) max_lvl = n_iss - n_pop;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // kind: 0 out data, 1 write addr, 2 write data, 3 read addr; expects base, base+1, ...
    task automatic chk_seq(input string tag, input int kind, input int idx0, input int n,
                           input int base);
        for (int i = 0; i < n; i++) begin
            int          j;
            logic [31:0] got;
            j   = idx0 + i;
            got = 32'hDEAD_BEEF;
            case (kind)
                0: if (j < out_q.size())     got = 32'(out_q[j]);
                1: if (j < wr_addr_q.size()) got = 32'(wr_addr_q[j]);
                2: if (j < wr_data_q.size()) got = 32'(wr_data_q[j]);
                default: if (j < rd_addr_q.size()) got = 32'(rd_addr_q[j]);
            endcase
            chk($sformatf("%s[%0d]", tag, j), got, 32'(base + i));
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        out_q.delete();
        out_cyc.delete();
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk($sformatf("send_%0h", d), 32'(done), 1);
    endtask

    task automatic send_frame(input logic [DW-1:0] base);
        for (int i = 0; i < 4; i++) send_word(base + DW'(i));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int k = 0; k < budget && out_q.size() < n; k++) @(posedge clk);
        #1;
        chk("out_count", 32'(out_q.size()), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_chk);
        $fatal(1);
    end

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        in_valid = 1'b1;
        in_data  = 16'hAAAA;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_wr_en",     32'(mem_wr_en), 0);
        chk("rst_rd_en",     32'(mem_rd_en), 0);
        chk("rst_bank",      32'(bank_sel), 0);
        chk("rst_swap_cnt",  32'(swap_cnt), 0);
        chk("rst_drop_cnt",  32'(drop_cnt), 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b1;
        clear_logs();

        // Frame 1 then frame 2 written while frame 1 drains
        send_frame(16'd1);
        chk("f1_bank", 32'(bank_sel), 1);
        chk("f1_swap_cnt", 32'(swap_cnt), 1);
        send_frame(16'd5);
        wait_out(8, 60);
        chk_seq("f12_wr_addr", 1, 0, 8, 0);
        chk_seq("f12_wr_data", 2, 0, 8, 1);
        chk_seq("f12_rd_addr", 3, 0, 8, 0);
        chk_seq("f12_out",     0, 0, 8, 1);
        chk("f1_consec", 32'(out_cyc[3] - out_cyc[0]), 3);
        chk("f2_consec", 32'(out_cyc[7] - out_cyc[4]), 3);
        @(negedge clk);
        chk("f2_bank", 32'(bank_sel), 0);
        chk("f2_swap_cnt", 32'(swap_cnt), 2);
        @(posedge clk);
        #1;

        // Sink stalled: only two reads may be outstanding
        out_ready = 1'b0;
        clear_logs();
        send_frame(16'h10);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_rd_issued", 32'(rd_addr_q.size()), 2);
        chk("stall_no_pop",    32'(out_q.size()), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_out(4, 40);
        chk_seq("stall_out",     0, 0, 4, 16'h10);
        chk_seq("stall_rd_addr", 3, 0, 4, 0);
        chk_seq("stall_wr_addr", 1, 0, 4, 0);
        chk("max_outstanding", 32'(max_lvl), 2);

        // Writer fills the next bank before the reader finishes
        out_ready = 1'b0;
        clear_logs();
        send_frame(16'h20);
        send_frame(16'h30);
        in_valid = 1'b1;
        in_data  = 16'h40;
`ifdef FB_DROP_EN
        @(negedge clk);
        chk("drop_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("drop_cnt", 32'(drop_cnt), 1);
        chk("drop_no_write", 32'(wr_addr_q.size()), 8);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
`else
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_wr_en", 32'(mem_wr_en), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_word(16'h40);
        chk("bp_drop_cnt", 32'(drop_cnt), 0);
        chk_seq("bp_wr_addr5", 1, 8, 1, 4);
        chk_seq("bp_wr_data5", 2, 8, 1, 16'h40);
`endif
        wait_out(8, 80);
        chk_seq("bp_out_a",     0, 0, 4, 16'h20);
        chk_seq("bp_out_b",     0, 4, 4, 16'h30);
        chk_seq("bp_rd_addr_a", 3, 0, 4, 4);
        chk_seq("bp_rd_addr_b", 3, 4, 4, 0);
        chk_seq("bp_wr_addr_a", 1, 0, 4, 4);
        chk_seq("bp_wr_addr_b", 1, 4, 4, 0);
        chk("bp_bank", 32'(bank_sel), 1);
        chk("bp_swap_cnt", 32'(swap_cnt), 5);

        // Reset with a partial frame written
        out_ready = 1'b0;
        send_word(16'h50);
        send_word(16'h51);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h52;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_wr_en",    32'(mem_wr_en), 0);
        chk("mid_rst_rd_en",    32'(mem_rd_en), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_bank",      32'(bank_sel), 0);
        chk("mid_rst_swap_cnt",  32'(swap_cnt), 0);
        chk("mid_rst_drop_cnt",  32'(drop_cnt), 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clear_logs();
        send_frame(16'h9);
        wait_out(4, 40);
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_out_count", 32'(out_q.size()), 4);
        chk_seq("post_rst_out",     0, 0, 4, 16'h9);
        chk_seq("post_rst_wr_addr", 1, 0, 4, 0);
        chk_seq("post_rst_rd_addr", 3, 0, 4, 0);
        chk("post_rst_bank", 32'(bank_sel), 1);
        chk("post_rst_swap_cnt", 32'(swap_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fb_pingpong_ctrl.md
FB_PINGPONG_CTRL -- requirements
Module: fb_pingpong_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel/word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, memory address width; MSB selects bank, FRAME_LEN = 2**(ADDR_WIDTH-1) words per bank.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  source word valid.
REQ-006 in_data  input  DATA_WIDTH  source word.
REQ-007 in_ready  output  1  controller accepts in_data this cycle.
REQ-008 out_valid  output  1  sink word valid.
REQ-009 out_data  output  DATA_WIDTH  sink word.
REQ-010 out_ready  input  1  sink accepts out_data.
REQ-011 mem_wr_en, mem_wr_addr[ADDR_WIDTH], mem_wr_data[DATA_WIDTH]  outputs  memory write port.
REQ-012 mem_rd_en, mem_rd_addr[ADDR_WIDTH]  outputs; mem_rd_data[DATA_WIDTH]  input  memory read port, data valid exactly 1 cycle after mem_rd_en.
REQ-013 bank_sel  output  1  current write bank; read bank = ~bank_sel.
REQ-014 swap_cnt  output  8  completed bank swaps, wraps 255->0.
REQ-015 drop_cnt  output  16  dropped input words (see Configuration).

Function
REQ-016 SHALL implement FSM states FILL (first frame, no reads), RUN, SWAP.
REQ-017 Write transfer SHALL occur when in_valid && in_ready: mem_wr_en=1, mem_wr_addr={bank_sel, wr_ptr}, mem_wr_data=in_data, combinationally same cycle; wr_ptr increments.
REQ-018 wr_full SHALL set when wr_ptr wraps from FRAME_LEN-1; in_ready SHALL be 0 while wr_full or in SWAP.
REQ-019 Reads SHALL be issued only in RUN with rd_issued < FRAME_LEN and (buffered + in-flight words) < 2; mem_rd_addr={~bank_sel, rd_ptr}.
REQ-020 Output SHALL use a 2-entry buffer; mem_rd_data captured 1 cycle after issue; out_valid high while buffer non-empty; pop on out_valid && out_ready; sustained throughput 1 word/cycle.
REQ-021 Read of a bank SHALL emit words in address order 0..FRAME_LEN-1.
REQ-022 FILL->SWAP when wr_full; RUN->SWAP when wr_full and all FRAME_LEN reads issued; simultaneous last write and last read issue SHALL enter SWAP next cycle.
REQ-023 SWAP SHALL last exactly 1 cycle: toggle bank_sel, clear wr_ptr, rd_ptr, rd_issued, wr_full, increment swap_cnt, go RUN.
REQ-024 Output buffer contents and in-flight read SHALL survive SWAP and drain normally.
REQ-025 mem_wr_en and mem_rd_en SHALL never assert in SWAP.

Reset
REQ-026 On reset: state FILL, bank_sel=0, pointers/counters 0, wr_full=0, output buffer empty, out_valid=0, in_ready=0 during reset cycle, mem_wr_en=0, mem_rd_en=0, swap_cnt=0, drop_cnt=0.
REQ-027 Reset mid-frame SHALL discard partial frames and buffered words; no output word emitted after reset until a full frame is written and swapped.

Configuration
REQ-028 Macro FB_DROP_EN: defined -> in_ready held 1 outside reset; words accepted while wr_full or in SWAP are not written, drop_cnt increments, saturates at 16'hFFFF.
REQ-029 FB_DROP_EN undefined -> backpressure per REQ-018, drop_cnt tied 0.

Structure
REQ-030 Shared package fb_pkg SHALL hold FSM state encoding (FILL, RUN, SWAP) and default DATA_WIDTH/ADDR_WIDTH constants.
REQ-031 Output buffer SHALL be sub-module fb_skid_buf (2-entry, DATA_WIDTH parameter, valid/ready both sides).

Verification (DATA_WIDTH=16, ADDR_WIDTH=3, FRAME_LEN=4, 1-cycle read memory model)
REQ-032 Reset, then write 1,2,3,4 back-to-back, out_ready=1 -> writes to addr 0..3, SWAP, bank_sel=1, reads addr 0..3, out_data 1,2,3,4 on consecutive cycles, swap_cnt=1.
REQ-033 Write second frame 5..8 while first drains -> writes addr 4..7; after both complete, bank_sel=0, output 5,6,7,8, swap_cnt=2.
REQ-034 out_ready=0 for 10 cycles mid-frame -> at most 2 words buffered, no read issued beyond credit, no word lost or duplicated on release.
REQ-035 Without FB_DROP_EN, write 5th word before reader finishes -> in_ready=0 until SWAP; with FB_DROP_EN -> in_ready=1, word dropped, drop_cnt=1.
REQ-036 Assert reset after 2 of 4 words written -> all outputs per REQ-026; subsequent frame 9,A,B,C output intact from addr 0.
